// File: rtl/adder_issue_ctrl.sv
// Issue/capture sequencer around an unregistered ripple-carry adder: registers operands,
// waits a fixed settle time, captures the result and hands it downstream.
module adder_issue_ctrl #(
    parameter int N      = 15,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic [N-1:0] add_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic [7:0]   res_count,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [N-1:0] add_a_q, add_a_d;
    logic [N-1:0] add_b_q, add_b_d;
    logic         add_cin_q, add_cin_d;
    logic [N-1:0] out_sum_q, out_sum_d;
    logic         out_cout_q, out_cout_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic         busy_q, busy_d;
    logic [7:0]   res_count_q, res_count_d;

    // Next-state and next-output logic; every output is computed one edge ahead.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        res_count_d = res_count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    add_a_d    = in_a;
                    add_b_d    = in_b;
                    add_cin_d  = in_cin;
                    cnt_d      = SETTLE_M1;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Operands have been stable for SETTLE full cycles here.
                    out_sum_d   = add_sum;
                    out_cout_d  = add_carry[N-1];
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    res_count_d = res_count_q + 8'd1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            res_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            res_count_q <= res_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign res_count = res_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Directed bench for adder_issue_ctrl: SETTLE=4 and SETTLE=1 instances, each driving
// a behavioural ripple-carry adder.
module tb_adder_issue_ctrl;

    localparam int N  = 15;
    localparam int S0 = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         in_valid0 = 1'b0, in_cin0 = 1'b0, out_ready0 = 1'b0;
    logic [N-1:0] in_a0 = '0, in_b0 = '0;
    logic         in_ready0, add_cin0, out_valid0, out_cout0, busy0;
    logic [N-1:0] add_a0, add_b0, add_sum0, add_carry0, out_sum0;
    logic [7:0]   res_count0;

    logic         in_valid1 = 1'b0, in_cin1 = 1'b0, out_ready1 = 1'b0;
    logic [N-1:0] in_a1 = '0, in_b1 = '0;
    logic         in_ready1, add_cin1, out_valid1, out_cout1, busy1;
    logic [N-1:0] add_a1, add_b1, add_sum1, add_carry1, out_sum1;
    logic [7:0]   res_count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] ripple(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic cin);
        logic [N-1:0] s;
        logic [N-1:0] cv;
        logic         c;
        c = cin;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ c;
            cv[i] = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            c     = cv[i];
        end
        return {cv, s};
    endfunction

    assign {add_carry0, add_sum0} = ripple(add_a0, add_b0, add_cin0);
    assign {add_carry1, add_sum1} = ripple(add_a1, add_b1, add_cin1);

    adder_issue_ctrl #(.N(N), .SETTLE(S0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .in_cin(in_cin0),
        .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
        .add_sum(add_sum0), .add_carry(add_carry0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_sum(out_sum0), .out_cout(out_cout0),
        .res_count(res_count0), .busy(busy0)
    );

    adder_issue_ctrl #(.N(N), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_carry(add_carry1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1),
        .res_count(res_count1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid0, returns edges elapsed since the accept edge.
    task automatic wait_valid0(output int cyc);
        cyc = 0;
        while (out_valid0 !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_txn(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin, input logic [N-1:0] exp_sum, input logic exp_cout,
                           input logic [7:0] exp_cnt);
        int cyc;
        in_a0 = a; in_b0 = b; in_cin0 = cin; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        chk({tag, "_add_a"}, 32'(add_a0), 32'(a));
        chk({tag, "_busy"}, 32'(busy0), 32'd1);
        chk({tag, "_in_ready"}, 32'(in_ready0), 32'd0);
        wait_valid0(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(S0));
        chk({tag, "_sum"}, 32'(out_sum0), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(out_cout0), 32'(exp_cout));
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid0), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready0), 32'd1);
        chk({tag, "_res_count"}, 32'(res_count0), 32'(exp_cnt));
    endtask

    initial begin
        int cyc;
        int highs;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_res_count", 32'(res_count0), 32'd0);
        chk("rst_add_a", 32'(add_a0), 32'd0);
        chk("rst_out_sum", 32'(out_sum0), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready0), 32'd1);

        // Basic transactions
        run_txn("t_3p5", 15'd3, 15'd5, 1'b0, 15'd8, 1'b0, 8'd1);
        run_txn("t_ovf", 15'h7FFF, 15'h0001, 1'b0, 15'h0000, 1'b1, 8'd2);
        run_txn("t_cin", 15'h0000, 15'h0000, 1'b1, 15'h0001, 1'b0, 8'd3);

        // Backpressure: result held, new operands ignored until handshake
        in_a0 = 15'h0100; in_b0 = 15'h0200; in_cin0 = 1'b0; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        wait_valid0(cyc);
        chk("bp_latency", 32'(cyc), 32'(S0));
        in_a0 = 15'h0011; in_b0 = 15'h0022; in_valid0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid0), 32'd1);
            chk("bp_sum", 32'(out_sum0), 32'h0300);
            chk("bp_in_ready", 32'(in_ready0), 32'd0);
            chk("bp_add_a", 32'(add_a0), 32'h0100);
            tick();
        end
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        chk("bp_hs_in_ready", 32'(in_ready0), 32'd1);
        chk("bp_hs_count", 32'(res_count0), 32'd4);
        tick();
        in_valid0 = 1'b0;
        chk("bp_new_add_a", 32'(add_a0), 32'h0011);
        wait_valid0(cyc);
        chk("bp_new_latency", 32'(cyc), 32'(S0));
        chk("bp_new_sum", 32'(out_sum0), 32'h0033);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        chk("bp_new_count", 32'(res_count0), 32'd5);

        // Reset two cycles into SETTLE
        in_a0 = 15'h0055; in_b0 = 15'h0066; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_add_a", 32'(add_a0), 32'd0);
        chk("mid_rst_count", 32'(res_count0), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid0), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_in_ready", 32'(in_ready0), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_rst_no_valid", 32'(out_valid0), 32'd0);
        chk("mid_rst_idle", 32'(busy0), 32'd0);

        // 257 back-to-back transactions, out_ready tied high
        in_a0 = 15'd1; in_b0 = 15'd2; in_cin0 = 1'b0;
        out_ready0 = 1'b1; in_valid0 = 1'b1;
        highs = 0;
        for (int e = 1; e <= 257 * (S0 + 2); e++) begin
            tick();
            if (in_ready0 === 1'b1) highs++;
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b0;
        chk("b2b_ready_pulses", 32'(highs), 32'd257);
        chk("b2b_res_count", 32'(res_count0), 32'd1);
        chk("b2b_idle", 32'(busy0), 32'd0);

        // SETTLE=1 instance
        in_a1 = 15'h1234; in_b1 = 15'h0FFF; in_cin1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("s1_valid_early", 32'(out_valid1), 32'd0);
        tick();
        chk("s1_valid", 32'(out_valid1), 32'd1);
        chk("s1_sum", 32'(out_sum1), 32'h2234);
        chk("s1_cout", 32'(out_cout1), 32'd0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("s1_count", 32'(res_count1), 32'd1);
        chk("s1_in_ready", 32'(in_ready1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
